// File: rtl/daisy_duty_gen_if.sv
// Control and output bundle for the programmable duty-cycle clock generator.
// The master side drives enable and load requests; the slave side produces the generated clock and status.
interface daisy_duty_gen_if #(
  parameter int unsigned W = 8
);
  logic         en;
  logic         load;
  logic [W-1:0] period_in;
  logic [W-1:0] high_in;
  logic         clkOut;
  logic         start;
  logic         ack;
  logic         busy;

  modport master (
    output en, load, period_in, high_in,
    input  clkOut, start, ack, busy
  );

  modport slave (
    input  en, load, period_in, high_in,
    output clkOut, start, ack, busy
  );
endinterface

// File: rtl/daisy_duty_gen.sv
// Programmable duty-cycle clock generator: clkOut has a period of P clk cycles and is high for the first H.
// New P/H settings are applied only at a period boundary, or immediately while stopped.
module daisy_duty_gen #(
  parameter int unsigned W          = 8,
  parameter int unsigned DEF_PERIOD = 4,
  parameter int unsigned DEF_HIGH   = 2
) (
  input logic             clk,
  input logic             rst,
  daisy_duty_gen_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state;
  logic [W-1:0] cnt;
  logic [W-1:0] p_act;
  logic [W-1:0] h_act;
  logic [W-1:0] p_pend;
  logic [W-1:0] h_pend;
  logic         pend;
  logic         clk_out_q;
  logic         start_q;
  logic         ack_q;
  logic         busy_q;

  logic [W-1:0] p_in;
  logic [W-1:0] p_take;
  logic [W-1:0] h_take;
  logic [W-1:0] h_next;
  logic [W-1:0] cnt_next;
  logic         wrap;
  logic         boundary;
  logic         apply;

  // An incoming load bypasses the pending registers when it lands on an apply edge.
  always_comb begin
    p_in     = (bus.period_in == '0) ? W'(1) : bus.period_in;
    p_take   = bus.load ? p_in : p_pend;
    h_take   = bus.load ? bus.high_in : h_pend;
    wrap     = (cnt == p_act - W'(1));
    boundary = (state == IDLE) || (bus.en && wrap);
    apply    = (bus.load || pend) && boundary;
    h_next   = apply ? h_take : h_act;
    cnt_next = '0;
    if (state == RUN && bus.en && !wrap) begin
      cnt_next = cnt + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      p_act     <= W'(DEF_PERIOD);
      h_act     <= W'(DEF_HIGH);
      p_pend    <= '0;
      h_pend    <= '0;
      pend      <= 1'b0;
      clk_out_q <= 1'b0;
      start_q   <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      ack_q <= apply;

      if (apply) begin
        p_act  <= p_take;
        h_act  <= h_take;
        pend   <= 1'b0;
        busy_q <= 1'b0;
      end else if (bus.load) begin
        p_pend <= p_in;
        h_pend <= bus.high_in;
        pend   <= 1'b1;
        busy_q <= 1'b1;
      end else begin
        busy_q <= pend;
      end

      // Leaving IDLE counts as a boundary, so the first period starts on the enabling edge.
      case (state)
        IDLE: begin
          state     <= bus.en ? RUN : IDLE;
          start_q   <= bus.en;
          clk_out_q <= bus.en && (cnt_next < h_next);
        end
        RUN: begin
          if (!bus.en) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            clk_out_q <= 1'b0;
          end else begin
            state     <= RUN;
            start_q   <= wrap;
            clk_out_q <= (cnt_next < h_next);
          end
        end
        default: begin
          state     <= IDLE;
          start_q   <= 1'b0;
          clk_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.clkOut = clk_out_q;
  assign bus.start  = start_q;
  assign bus.ack    = ack_q;
  assign bus.busy   = busy_q;

endmodule

// File: doc/daisy_duty_gen.md
# daisy_duty_gen

Programmable duty-cycle clock generator. Divides the system clock `clk` into an output clock `clkOut` with a period of `period` clk cycles, high for the first `high` cycles of each period. It sits directly upstream of the duty-cycle measurement stage and drives that stage's clock input. New settings are loaded through a strobe and applied only at a period boundary, so `clkOut` never shows a runt pulse.

## Interface
- `W`, default 8: width of the period and high-time counts.
- `DEF_PERIOD`, default 4: active period after reset (must be ≥1).
- `DEF_HIGH`, default 2: active high time after reset.
- `clk`, input, 1: system clock; all state is updated on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: run enable. Low means stop and hold the output low.
- `load`, input, 1: single-cycle strobe that captures `period_in` and `high_in`.
- `period_in`, input, W: requested period in clk cycles. 0 is treated as 1.
- `high_in`, input, W: requested high time in clk cycles.
- `clkOut`, output, 1: generated clock, driven by a register.
- `start`, output, 1: one-cycle pulse, asserted in the cycle where the counter is 0 (first cycle of each period).
- `ack`, output, 1: one-cycle pulse, asserted in the cycle after a pending load becomes active.
- `busy`, output, 1: a load is pending and has not yet been applied.

## Operation
Registers:
- `cnt` (W bits)
- `run`
- active `P`, `H`
- pending `pP`, `pH`, and `pend` (pending-valid flag)

Reset values:
- `cnt`=0, `run`=0
- `P`=DEF_PERIOD, `H`=DEF_HIGH
- `pend`=0
- `clkOut`=0, `start`=0, `ack`=0, `busy`=0

Load capture:
- On `load`=1, write `pP`=max(`period_in`,1) and `pH`=`high_in`, and set `pend`.
- Another load while `pend`=1 overwrites the pending values; the last load wins.

States:
- IDLE (`run`=0)
- RUN (`run`=1)

IDLE, each edge:
- `cnt`=0, `clkOut`=0, `start`=0.
- A pending load, or a `load` sampled on this edge, is applied immediately to `P`/`H`; `ack` pulses and `pend` clears.
- If `en`=1, go to RUN via a boundary edge.

RUN, each edge:
- If `en`=0: go to IDLE, `cnt`=0, `clkOut`=0.
- Else, if this is a boundary (`cnt`=`P`-1, or entry from IDLE): `cnt_next`=0 and `start`=1. If `pend`=1 or `load`=1 on this edge, `P`/`H` take the pending or incoming values, the load bypasses `pend`, and `ack` pulses.
- Else: `cnt_next`=`cnt`+1.
- `clkOut` is set to (`cnt_next` < `H_next`), so the output uses the values that will be active after the edge.

Arithmetic: compare and count are unsigned W-bit values. `cnt` never exceeds `P`-1, so there is no wrap inside W bits.

Degenerate settings fall out of the compare, with no special casing:
- `H`=0: `clkOut` constant low.
- `H`≥`P`: `clkOut` constant high.
- `P`=1: the counter stays at 0, `start` is high every cycle, and `clkOut`=(`H`≥1).

## Timing
- Start latency: with `en` sampled high on edge t0 from IDLE, `clkOut` and `start` are valid after t0. The first high phase lasts `H` cycles.
- Steady state: `clkOut` has period `P` clk cycles and high time `H` clk cycles, giving duty cycle `H`/`P`.
- Stop latency: `en` sampled low at edge t forces `clkOut`=0 after t, even mid-high-phase. This is the only permitted truncation.
- Load latency in RUN: the new values take effect at the first boundary edge at or after the load edge. `ack` coincides with that boundary's `start`. `busy` is high from the edge after the load until the apply edge; it stays low for a bypass.
- Load and `en` fall on the same edge: the values are applied by IDLE on the next edge.
- `rst` asserted mid-operation: all outputs go to their reset values immediately and asynchronously. The pending load is discarded and no `ack` is produced.

## Test plan
1. Reset, then `en`=1 with defaults P=4, H=2 → `clkOut` pattern 1100 repeating; `start` every 4th cycle, aligned to each rising edge of `clkOut`.
2. In RUN at P=4/H=2, load P=10/H=3 at cnt=1 → two more cycles of the old period, then at the boundary `ack`=`start`=1 and the pattern becomes 1110000000. `busy` is high for exactly 2 cycles.
3. Load twice while pending (P=6/H=1, then P=5/H=4) → only P=5/H=4 is applied, with a single `ack`.
4. Degenerate settings:
   - Load H=0 → `clkOut` constant 0.
   - Load H=12 with P=8 → `clkOut` constant 1.
   - Load P=0/H=1 → treated as P=1; `clkOut`=1 and `start`=1 every cycle.
5. Drop `en` mid-high-phase → `clkOut`=0 on the next edge. Load P=3/H=1 while idle → `ack` on the next edge. Raise `en` → pattern 100.
6. Assert `rst` asynchronously mid-period with a load pending → all outputs go to 0 immediately. After release, defaults apply (1100 pattern) and no `ack` is seen.
